// File: rtl/chan_sel_bin_scheduler.sv
// -----------------------------------------------------------------------------
// chan_sel_bin_scheduler
//
// Round-robin scheduler for the per-bin channel-select words (ch_bin0..N-1) of
// the wvl readout. At frame boundaries (sync_in) it steps through the enabled
// bins. It holds each bin for a programmable number of frames and drives the
// active channel to the snapshot/capture path. Lives in the user_clk domain.
//
// Optional feature macro: CHAN_SEL_SCHED_STATS_EN
//   defined   -> sweep_count counts completed sweeps (wraps 0xFFFFFFFF -> 0)
//   undefined -> sweep_count is tied to 0 and no counter logic is built
//
// Ports
//   user_clk     in   sole clock
//   user_rst     in   asynchronous, active-high reset
//   run          in   1 = sequencing enabled; 0 forces IDLE on the next cycle
//   sync_in      in   one-cycle frame-start pulse
//   ch_bin_flat  in   N_BINS x 32-bit words; bit31 = enable, [CH_W-1:0] = channel
//   dwell_frames in   frames per bin (0 behaves as 1)
//   busy         in   downstream capture in progress; blocks the advance
//   ch_sel_out   out  active channel
//   bin_idx      out  active bin index
//   sel_valid    out  ch_sel_out / bin_idx are valid
//   bin_start    out  one-cycle pulse when a new bin becomes active
//   sweep_count  out  completed sweeps
// -----------------------------------------------------------------------------
module chan_sel_bin_scheduler #(
  parameter int N_BINS  = 4,
  parameter int CH_W    = 9,
  parameter int DWELL_W = 16,
  localparam int IDX_W  = (N_BINS > 1) ? $clog2(N_BINS) : 1
) (
  input  logic                 user_clk,
  input  logic                 user_rst,
  input  logic                 run,
  input  logic                 sync_in,
  input  logic [N_BINS*32-1:0] ch_bin_flat,
  input  logic [DWELL_W-1:0]   dwell_frames,
  input  logic                 busy,
  output logic [CH_W-1:0]      ch_sel_out,
  output logic [IDX_W-1:0]     bin_idx,
  output logic                 sel_valid,
  output logic                 bin_start,
  output logic [31:0]          sweep_count
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SYNC = 3'd1,
    ST_ADVANCE   = 3'd2,
    ST_DWELL     = 3'd3,
    ST_HOLD      = 3'd4
  } state_t;

  localparam logic [DWELL_W-1:0] ONE_FRAME = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_t                       state_r;
  logic [N_BINS*32-1:0]         stage1_r;
  logic [N_BINS*32-1:0]         stage2_r;
  logic [N_BINS-1:0]            shadow_en_r;
  logic [N_BINS-1:0][CH_W-1:0]  shadow_ch_r;
  logic [DWELL_W-1:0]           cnt_r;
  logic                         from_start_r;

  logic [N_BINS-1:0]            word_stable_s;
  logic [N_BINS-1:0]            stage2_en_s;
  logic [N_BINS-1:0]            load_en_s;
  logic [N_BINS-1:0][CH_W-1:0]  load_ch_s;
  logic                         any_en_s;
  logic [DWELL_W-1:0]           dwell_eff_s;
  logic [31:0]                  start_s;
  logic [31:0]                  sum_s;
  logic [31:0]                  cand_s;
  logic [IDX_W-1:0]             cand_idx_s;
  logic [IDX_W-1:0]             next_idx_s;
  logic                         found_s;
  logic                         adv_s;

  // Per-bin view of the synchronised words. A word only loads into the shadow
  // when both pipeline stages agree, so a word caught mid-update is ignored.
  for (genvar k = 0; k < N_BINS; k++) begin : g_bin
    assign word_stable_s[k] = (stage1_r[32*k +: 32] == stage2_r[32*k +: 32]);
    assign stage2_en_s[k]   = stage2_r[32*k + 31];
    assign load_en_s[k]     = word_stable_s[k] ? stage2_r[32*k + 31]     : shadow_en_r[k];
    assign load_ch_s[k]     = word_stable_s[k] ? stage2_r[32*k +: CH_W]  : shadow_ch_r[k];
  end

  assign any_en_s    = |stage2_en_s;
  assign dwell_eff_s = (dwell_frames == {DWELL_W{1'b0}}) ? ONE_FRAME : dwell_frames;
  assign adv_s       = run && (state_r == ST_ADVANCE);

  // Next-bin search over the post-load shadow: idx+1 .. N-1 then 0 .. idx.
  // A fresh start searches from N-1 so the lowest enabled bin wins.
  always_comb begin
    found_s    = 1'b0;
    next_idx_s = {IDX_W{1'b0}};
    sum_s      = 32'd0;
    cand_s     = 32'd0;
    cand_idx_s = {IDX_W{1'b0}};
    if (from_start_r) begin
      start_s = 32'(N_BINS - 1);
    end else begin
      start_s = 32'(bin_idx);
    end
    for (int i = 1; i <= N_BINS; i++) begin
      sum_s      = start_s + 32'(i);
      cand_s     = (sum_s >= 32'(N_BINS)) ? (sum_s - 32'(N_BINS)) : sum_s;
      cand_idx_s = IDX_W'(cand_s);
      if (!found_s && load_en_s[cand_idx_s]) begin
        found_s    = 1'b1;
        next_idx_s = cand_idx_s;
      end else begin
        next_idx_s = next_idx_s;
      end
    end
  end

  // Two-stage capture of the software words into the user_clk domain.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      stage1_r <= '0;
      stage2_r <= '0;
    end else begin
      stage1_r <= ch_bin_flat;
      stage2_r <= stage1_r;
    end
  end

  // Shadow words change only as a bin becomes active, never mid-dwell.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      shadow_en_r <= '0;
      shadow_ch_r <= '0;
    end else if (adv_s) begin
      shadow_en_r <= load_en_s;
      shadow_ch_r <= load_ch_s;
    end else begin
      shadow_en_r <= shadow_en_r;
      shadow_ch_r <= shadow_ch_r;
    end
  end

  // Scheduler FSM with registered outputs. run=0 overrides every state,
  // including a coincident sync_in.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_r      <= ST_IDLE;
      ch_sel_out   <= '0;
      bin_idx      <= '0;
      sel_valid    <= 1'b0;
      bin_start    <= 1'b0;
      cnt_r        <= '0;
      from_start_r <= 1'b1;
    end else if (!run) begin
      state_r      <= ST_IDLE;
      sel_valid    <= 1'b0;
      bin_start    <= 1'b0;
      cnt_r        <= '0;
      from_start_r <= 1'b1;
    end else begin
      bin_start <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          sel_valid    <= 1'b0;
          from_start_r <= 1'b1;
          state_r      <= ST_WAIT_SYNC;
        end
        ST_WAIT_SYNC: begin
          if (sync_in && any_en_s) begin
            from_start_r <= 1'b1;
            state_r      <= ST_ADVANCE;
          end else begin
            state_r <= ST_WAIT_SYNC;
          end
        end
        ST_ADVANCE: begin
          if (found_s) begin
            bin_idx      <= next_idx_s;
            ch_sel_out   <= load_ch_s[next_idx_s];
            bin_start    <= 1'b1;
            sel_valid    <= 1'b1;
            cnt_r        <= ONE_FRAME;
            from_start_r <= 1'b0;
            state_r      <= ST_DWELL;
          end else begin
            sel_valid    <= 1'b0;
            from_start_r <= 1'b1;
            state_r      <= ST_WAIT_SYNC;
          end
        end
        ST_DWELL: begin
          // Compared against the live dwell_frames so a shortened dwell ends
          // on the next frame boundary.
          if (sync_in) begin
            if (cnt_r >= dwell_eff_s) begin
              state_r <= busy ? ST_HOLD : ST_ADVANCE;
            end else begin
              cnt_r <= cnt_r + ONE_FRAME;
            end
          end else begin
            state_r <= ST_DWELL;
          end
        end
        ST_HOLD: begin
          if (sync_in && !busy) begin
            state_r <= ST_ADVANCE;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          sel_valid <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CHAN_SEL_SCHED_STATS_EN
  logic        wrap_s;
  logic [31:0] sweep_r;

  // A sweep completes when the search wraps back to the same or a lower bin;
  // the initial pick after a fresh start is not a wrap.
  assign wrap_s = !from_start_r && (next_idx_s <= bin_idx);

  // Sweep counter, free-running modulo 2^32.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      sweep_r <= 32'd0;
    end else if (adv_s && found_s && wrap_s) begin
      sweep_r <= sweep_r + 32'd1;
    end else begin
      sweep_r <= sweep_r;
    end
  end

  assign sweep_count = sweep_r;
`else
  assign sweep_count = 32'd0;
`endif

endmodule

// File: tb/tb_chan_sel_bin_scheduler.sv
// -----------------------------------------------------------------------------
// Bench for chan_sel_bin_scheduler. Each bin_start pulse is matched against a
// queue of expected {cycle, bin, channel, sweep} entries pushed when the sync
// that should cause it is driven. Steady-state outputs are checked from a
// table of frame rows. Hand-written sequences cover the multi-cycle cases.
// -----------------------------------------------------------------------------
module tb_chan_sel_bin_scheduler;

  localparam int N_BINS  = 4;
  localparam int CH_W    = 9;
  localparam int DWELL_W = 16;
  localparam logic [31:0] EN = 32'h8000_0000;
`ifdef CHAN_SEL_SCHED_STATS_EN
  localparam logic [31:0] SW_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] SW_MASK = 32'h0000_0000;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 run = 1'b0;
  logic                 sync_in = 1'b0;
  logic [N_BINS*32-1:0] ch_bin_flat = '0;
  logic [DWELL_W-1:0]   dwell_frames = '0;
  logic                 busy = 1'b0;
  logic [CH_W-1:0]      ch_sel_out;
  logic [1:0]           bin_idx;
  logic                 sel_valid;
  logic                 bin_start;
  logic [31:0]          sweep_count;

  chan_sel_bin_scheduler #(.N_BINS(N_BINS), .CH_W(CH_W), .DWELL_W(DWELL_W)) dut (
    .user_clk(clk), .user_rst(rst), .run(run), .sync_in(sync_in),
    .ch_bin_flat(ch_bin_flat), .dwell_frames(dwell_frames), .busy(busy),
    .ch_sel_out(ch_sel_out), .bin_idx(bin_idx), .sel_valid(sel_valid),
    .bin_start(bin_start), .sweep_count(sweep_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int bin; int ch; int sweep; } exp_t;
  typedef struct { bit adv; int bin; int ch; int sweep; } row_t;

  exp_t exp_q[$];
  exp_t mon_e;
  row_t rows[13];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Scoreboard: every bin_start must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && bin_start) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_bin_start: pulse at cycle %0d bin %0d ch %0d, none expected",
                 cyc, bin_idx, ch_sel_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("start_cycle", cyc, mon_e.cyc);
        check("start_bin", 32'(bin_idx), mon_e.bin);
        check("start_ch", 32'(ch_sel_out), mon_e.ch);
        check("start_valid", 32'(sel_valid), 32'd1);
        check("start_sweep", sweep_count, mon_e.sweep & SW_MASK);
      end
    end
  end

  task automatic set_bin(input int k, input logic [31:0] v);
    ch_bin_flat[32*k +: 32] = v;
  endtask

  // One-cycle sync; if an advance is expected, outputs appear two cycles later.
  task automatic do_sync(input bit adv, input int bin, input int ch, input int sweep);
    exp_t e;
    @(posedge clk); #1;
    sync_in = 1'b1;
    if (adv) begin
      e.cyc = cyc + 2; e.bin = bin; e.ch = ch; e.sweep = sweep;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    sync_in = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_out(input string tag, input bit v, input int bin, input int ch, input int sweep);
    check({tag, "_valid"}, 32'(sel_valid), 32'(v));
    check({tag, "_bin"}, 32'(bin_idx), bin);
    check({tag, "_ch"}, 32'(ch_sel_out), ch);
    check({tag, "_sweep"}, sweep_count, sweep & SW_MASK);
  endtask

  task automatic run_row(input int r, input int gap);
    do_sync(rows[r].adv, rows[r].bin, rows[r].ch, rows[r].sweep);
    wait_cyc(gap);
    check_out($sformatf("row%0d", r), 1'b1, rows[r].bin, rows[r].ch, rows[r].sweep);
  endtask

  initial begin
    // Frame table: {advance expected, bin, channel, sweep} after each sync.
    rows[0]  = '{1'b1, 0,   5, 0};
    rows[1]  = '{1'b0, 0,   5, 0};
    rows[2]  = '{1'b1, 2,  17, 0};
    rows[3]  = '{1'b0, 2,  17, 0};
    rows[4]  = '{1'b1, 3, 300, 0};
    rows[5]  = '{1'b0, 3, 300, 0};
    rows[6]  = '{1'b1, 0,   5, 1};
    rows[7]  = '{1'b0, 0,   5, 1};
    rows[8]  = '{1'b1, 2,  17, 1};
    rows[9]  = '{1'b1, 1,  42, 1};
    rows[10] = '{1'b1, 1,  42, 2};
    rows[11] = '{1'b1, 1,  42, 3};
    rows[12] = '{1'b1, 1,  42, 4};

    // Reset state
    wait_cyc(4);
    check_out("reset", 1'b0, 0, 0, 0);
    check("reset_bin_start", 32'(bin_start), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Test 1: bins 0,2,3 enabled, dwell 2, sync every 64 cycles
    set_bin(0, EN | 32'd5);
    set_bin(1, 32'h0000_0055);
    set_bin(2, EN | 32'd17);
    set_bin(3, EN | 32'd300);
    dwell_frames = 16'd2;
    run = 1'b1;
    wait_cyc(6);
    check("wait_valid", 32'(sel_valid), 32'd0);
    for (int r = 0; r < 9; r++) run_row(r, 62);

    // run low: invalid, index/channel hold
    run = 1'b0;
    wait_cyc(3);
    check_out("runlow", 1'b0, 2, 17, 1);

    // Test 2: only bin 1 (ch 42), dwell 0 behaves as 1
    set_bin(0, 32'd0); set_bin(1, EN | 32'd42); set_bin(2, 32'd0); set_bin(3, 32'd0);
    dwell_frames = 16'd0;
    run = 1'b1;
    wait_cyc(5);
    for (int r = 9; r < 13; r++) run_row(r, 14);

    // Test 3: busy across the dwell-ending sync -> HOLD
    busy = 1'b1;
    do_sync(1'b0, 0, 0, 0);
    wait_cyc(5);
    check_out("hold1", 1'b1, 1, 42, 4);
    do_sync(1'b0, 0, 0, 0);
    wait_cyc(3);
    busy = 1'b0;
    wait_cyc(8);
    check_out("hold2", 1'b1, 1, 42, 4);
    do_sync(1'b1, 1, 42, 5);
    wait_cyc(5);

    // Test 4: unstable ch_bin2 during ADVANCE keeps the old channel
    run = 1'b0;
    wait_cyc(2);
    set_bin(0, EN | 32'd5); set_bin(1, 32'd0); set_bin(2, EN | 32'd17); set_bin(3, EN | 32'd300);
    dwell_frames = 16'd1;
    run = 1'b1;
    wait_cyc(6);
    do_sync(1'b1, 0, 5, 5);
    wait_cyc(8);
    @(posedge clk); #1 set_bin(2, EN | 32'd100);
    @(posedge clk); #1 set_bin(2, EN | 32'd200);
    sync_in = 1'b1;
    exp_q.push_back('{cyc + 2, 2, 17, 5});
    @(posedge clk); #1 sync_in = 1'b0;
    wait_cyc(8);
    check_out("unstable", 1'b1, 2, 17, 5);
    do_sync(1'b1, 3, 300, 5); wait_cyc(8);
    do_sync(1'b1, 0, 5, 6);   wait_cyc(8);
    do_sync(1'b1, 2, 200, 6); wait_cyc(8);
    check_out("stable", 1'b1, 2, 200, 6);

    // Test 5: nothing enabled, then bin 3 (ch 7)
    run = 1'b0;
    wait_cyc(2);
    ch_bin_flat = '0;
    run = 1'b1;
    wait_cyc(6);
    for (int i = 0; i < 3; i++) begin
      do_sync(1'b0, 0, 0, 0);
      wait_cyc(6);
      check("none_valid", 32'(sel_valid), 32'd0);
    end
    set_bin(3, EN | 32'd7);
    wait_cyc(4);
    do_sync(1'b1, 3, 7, 6);
    wait_cyc(4);
    check_out("bin3", 1'b1, 3, 7, 6);

    // Test 6: async reset mid-dwell
    dwell_frames = 16'd4;
    do_sync(1'b0, 0, 0, 0);
    wait_cyc(3);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check_out("async_rst", 1'b0, 0, 0, 0);
    check("async_rst_start", 32'(bin_start), 32'd0);
    set_bin(1, EN | 32'd9);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_cyc(4);
    do_sync(1'b1, 1, 9, 0); wait_cyc(4);
    do_sync(1'b0, 0, 0, 0); wait_cyc(4);
    do_sync(1'b0, 0, 0, 0); wait_cyc(4);
    // Counter is 3; shortening dwell to 2 ends it on the next sync.
    dwell_frames = 16'd2;
    wait_cyc(2);
    do_sync(1'b1, 3, 7, 0); wait_cyc(4);
    check_out("short_dwell", 1'b1, 3, 7, 0);

    // sync and run falling together: no advance, values held
    dwell_frames = 16'd1;
    @(posedge clk); #1;
    sync_in = 1'b1; run = 1'b0;
    @(posedge clk); #1 sync_in = 1'b0;
    wait_cyc(5);
    check_out("run_wins", 1'b0, 3, 7, 0);

    wait_cyc(4);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
